// File: rtl/lights_pkg.sv
// Shared types for the lights instruction stream: opcodes, coordinates,
// the packed instruction word and the evaluator FSM states.
package lights_pkg;

    typedef enum logic [1:0] {
        OP_OFF    = 2'd0,
        OP_ON     = 2'd1,
        OP_TOGGLE = 2'd2,
        OP_RSVD   = 2'd3
    } op_t;

    localparam int COORD_WIDTH = 10;

    typedef logic [COORD_WIDTH-1:0] coord_t;

    typedef struct packed {
        op_t    op;
        coord_t x0;
        coord_t y0;
        coord_t x1;
        coord_t y1;
    } instr_t;

    localparam int INSTRUCTION_WIDTH = $bits(instr_t);

    typedef enum logic [1:0] {
        ST_PASS  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Inclusive rectangle test; an inverted rectangle (x0>x1 or y0>y1) never hits.
    function automatic logic in_rect(input coord_t x, input coord_t y, input instr_t i);
        return (x >= i.x0) && (x <= i.x1) && (y >= i.y0) && (y <= i.y1);
    endfunction

endpackage

// File: rtl/brightness_evaluator_if.sv
// Instruction stream from the replay buffer: ready/valid with an end-of-list marker.
interface brightness_evaluator_if
    import lights_pkg::*;
();
    logic                         instr_valid;
    logic                         instr_ready;
    logic                         instr_last;
    logic [INSTRUCTION_WIDTH-1:0] instr_data;

    modport master (output instr_valid, output instr_last, output instr_data, input instr_ready);
    modport slave  (input instr_valid, input instr_last, input instr_data, output instr_ready);
endinterface

// File: rtl/brightness_lane.sv
// One light's brightness counter: rectangle hit test, op apply with floor/saturation, clear.
module brightness_lane
    import lights_pkg::*;
#(
    parameter int BRIGHT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  coord_t                  x,
    input  coord_t                  y,
    input  logic                    apply,
    input  logic                    clear,
    input  instr_t                  instr,
    output logic [BRIGHT_WIDTH-1:0] bright
);

    localparam logic [BRIGHT_WIDTH-1:0] MAX_B = '1;

    logic hit;

    // Hit decode for this lane's coordinate.
    always_comb begin
        hit = in_rect(x, y, instr);
    end

    // Counter update; clear (slice fold) wins over a concurrent apply.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bright <= '0;
        end else if (clear) begin
            bright <= '0;
        end else if (apply && hit) begin
            case (instr.op)
                OP_OFF:    if (bright != '0) bright <= bright - BRIGHT_WIDTH'(1);
                OP_ON:     if (bright != MAX_B) bright <= bright + BRIGHT_WIDTH'(1);
                OP_TOGGLE: begin
                    if (bright >= MAX_B - BRIGHT_WIDTH'(1)) bright <= MAX_B;
                    else                                    bright <= bright + BRIGHT_WIDTH'(2);
                end
                default:   bright <= bright;
            endcase
        end
    end

endmodule

// File: rtl/brightness_evaluator.sv
// Reader end of the instruction replay buffer. Replays the full list once per
// slice of LANES lights, then folds the slice into the running total.
module brightness_evaluator
    import lights_pkg::*;
#(
    parameter int GRID_SIZE    = 1000,
    parameter int LANES        = 8,
    parameter int BRIGHT_WIDTH = 16,
    parameter int TOTAL_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    brightness_evaluator_if.slave  instr,
    output logic                   done,
    output logic [TOTAL_WIDTH-1:0] total_brightness
);

    if (GRID_SIZE % LANES != 0) begin : g_bad_cfg
        $error("brightness_evaluator: GRID_SIZE must be a multiple of LANES");
    end

    localparam coord_t X_LAST = coord_t'(GRID_SIZE - LANES);
    localparam coord_t Y_LAST = coord_t'(GRID_SIZE - 1);

    state_t                  state;
    logic                    ready_q;
    coord_t                  x_base;
    coord_t                  y;
    logic                    accept;
    logic                    clear;
    instr_t                  beat;
    logic [BRIGHT_WIDTH-1:0] lane_bright [LANES];
    logic [TOTAL_WIDTH-1:0]  lane_sum;

    assign instr.instr_ready = ready_q;
    assign beat   = instr_t'(instr.instr_data);
    assign accept = instr.instr_valid && ready_q;
    assign clear  = (state == ST_ACCUM);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        brightness_lane #(.BRIGHT_WIDTH(BRIGHT_WIDTH)) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .x       (x_base + coord_t'(i)),
            .y       (y),
            .apply   (accept),
            .clear   (clear),
            .instr   (beat),
            .bright  (lane_bright[i])
        );
    end

    // Slice sum across all lanes.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + TOTAL_WIDTH'(lane_bright[i]);
        end
    end

    // Sequencer: replay pass, one-cycle fold, then park in DONE until reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= ST_PASS;
            ready_q          <= 1'b0;
            done             <= 1'b0;
            total_brightness <= '0;
            x_base           <= '0;
            y                <= '0;
        end else begin
            case (state)
                ST_PASS: begin
                    if (accept && instr.instr_last) begin
                        state   <= ST_ACCUM;
                        ready_q <= 1'b0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    total_brightness <= total_brightness + lane_sum;
                    if (x_base == X_LAST) begin
                        x_base <= '0;
                        y      <= y + coord_t'(1);
                    end else begin
                        x_base <= x_base + coord_t'(LANES);
                    end
                    if (x_base == X_LAST && y == Y_LAST) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        ready_q <= 1'b0;
                    end else begin
                        state   <= ST_PASS;
                        ready_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    ready_q <= 1'b0;
                    done    <= 1'b1;
                end
                default: begin
                    state   <= ST_PASS;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_brightness_evaluator.sv
// Directed bench: a 4x4 grid with 2 lanes for the functional cases and a
// 40x40 grid with 8 lanes for the full-width lane configuration.
module tb_brightness_evaluator;
    import lights_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n  = 1'b0;
    logic        reset_n2 = 1'b0;
    logic        done, done2;
    logic [31:0] total, total2;

    brightness_evaluator_if bif ();
    brightness_evaluator_if bif2 ();

    brightness_evaluator #(.GRID_SIZE(4), .LANES(2), .BRIGHT_WIDTH(16), .TOTAL_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .instr(bif.slave), .done(done), .total_brightness(total));

    brightness_evaluator #(.GRID_SIZE(40), .LANES(8), .BRIGHT_WIDTH(16), .TOTAL_WIDTH(32)) dut_big (
        .clk(clk), .reset_n(reset_n2), .instr(bif2.slave), .done(done2), .total_brightness(total2));

    int tests_run    = 0;
    int tests_failed = 0;

    instr_t prog [4];
    int     prog_len;

    function automatic instr_t mk(op_t op, int x0, int y0, int x1, int y1);
        instr_t r;
        r.op = op;
        r.x0 = coord_t'(x0);
        r.y0 = coord_t'(y0);
        r.x1 = coord_t'(x1);
        r.y1 = coord_t'(y1);
        return r;
    endfunction

    task automatic idle_inputs();
        bif.instr_valid  = 1'b0;
        bif.instr_last   = 1'b0;
        bif.instr_data   = '0;
        bif2.instr_valid = 1'b0;
        bif2.instr_last  = 1'b0;
        bif2.instr_data  = '0;
    endtask

    task automatic do_reset(input bit big);
        @(negedge clk);
        idle_inputs();
        if (big) reset_n2 = 1'b0; else reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (big) reset_n2 = 1'b1; else reset_n = 1'b1;
    endtask

    // Streams prog repeatedly until done, an abort beat count, or the cycle budget.
    task automatic run_list(input bit big, input int gap_pct, input int abort_beats,
                            input int budget, output int passes, output int beats,
                            output bit timed_out);
        int  idx = 0;
        bit  v, rdy, lst;
        passes    = 0;
        beats     = 0;
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (big ? done2 : done) begin timed_out = 1'b0; break; end
            if (abort_beats >= 0 && beats == abort_beats) begin timed_out = 1'b0; break; end
            v   = ($urandom_range(99) >= gap_pct);
            lst = (idx == prog_len - 1);
            if (big) begin
                bif2.instr_valid = v; bif2.instr_last = lst; bif2.instr_data = prog[idx];
                rdy = bif2.instr_ready;
            end else begin
                bif.instr_valid = v; bif.instr_last = lst; bif.instr_data = prog[idx];
                rdy = bif.instr_ready;
            end
            if (v && rdy) begin
                beats++;
                if (lst) begin passes++; idx = 0; end
                else idx++;
            end
        end
        idle_inputs();
    endtask

    task automatic check_run(input string name, input bit timed_out, input int passes,
                             input int exp_passes, input int beats, input int exp_beats,
                             input logic [31:0] got_total, input logic [31:0] exp_total);
        tests_run++;
        if (timed_out !== 1'b0) begin
            tests_failed++; $display("FAIL %s_timeout: done never asserted within budget", name);
        end
        tests_run++;
        if (got_total !== exp_total) begin
            tests_failed++; $display("FAIL %s_total: got %0d expected %0d", name, got_total, exp_total);
        end
        tests_run++;
        if (passes !== exp_passes) begin
            tests_failed++; $display("FAIL %s_passes: got %0d expected %0d", name, passes, exp_passes);
        end
        tests_run++;
        if (beats !== exp_beats) begin
            tests_failed++; $display("FAIL %s_beats: got %0d expected %0d", name, beats, exp_beats);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (bif.instr_ready !== 1'b0) begin
            tests_failed++; $display("FAIL reset_ready: got %b expected 0", bif.instr_ready);
        end
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++; $display("FAIL reset_done: got %b expected 0", done);
        end
        tests_run++;
        if (total !== 32'd0) begin
            tests_failed++; $display("FAIL reset_total: got %0d expected 0", total);
        end
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bif.instr_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_ready_after: got %b expected 1", bif.instr_ready);
        end
    endtask

    task automatic test_single_on();
        int p, b; bit to; int bad = 0;
        prog[0] = mk(OP_ON, 0, 0, 0, 0); prog_len = 1;
        do_reset(1'b0);
        run_list(1'b0, 0, -1, 500, p, b, to);
        check_run("single_on", to, p, 8, b, 8, total, 32'd1);
        repeat (5) begin
            @(negedge clk);
            if (bif.instr_ready !== 1'b0 || done !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++; $display("FAIL done_hold: ready/done wrong in %0d of 5 cycles after done", bad);
        end
    endtask

    task automatic test_toggle_and_floor();
        int p, b; bit to;
        prog[0] = mk(OP_TOGGLE, 0, 0, 3, 3); prog_len = 1;
        do_reset(1'b0);
        run_list(1'b0, 0, -1, 500, p, b, to);
        check_run("toggle_all", to, p, 8, b, 8, total, 32'd32);
        prog[0] = mk(OP_OFF, 0, 0, 3, 3);
        do_reset(1'b0);
        run_list(1'b0, 0, -1, 500, p, b, to);
        check_run("off_floor", to, p, 8, b, 8, total, 32'd0);
        prog[0] = mk(OP_ON, 3, 0, 0, 3);
        do_reset(1'b0);
        run_list(1'b0, 0, -1, 500, p, b, to);
        check_run("inverted_rect", to, p, 8, b, 8, total, 32'd0);
    endtask

    task automatic load_mixed();
        prog[0] = mk(OP_ON,     0, 0, 3, 3);
        prog[1] = mk(OP_OFF,    1, 1, 2, 2);
        prog[2] = mk(OP_OFF,    1, 1, 2, 2);
        prog[3] = mk(OP_TOGGLE, 3, 0, 3, 0);
        prog_len = 4;
    endtask

    task automatic test_mixed();
        int p, b; bit to;
        load_mixed();
        do_reset(1'b0);
        run_list(1'b0, 0, -1, 500, p, b, to);
        check_run("mixed", to, p, 8, b, 32, total, 32'd14);
    endtask

    task automatic test_gaps();
        int p, b; bit to;
        load_mixed();
        do_reset(1'b0);
        run_list(1'b0, 50, -1, 2000, p, b, to);
        check_run("gaps", to, p, 8, b, 32, total, 32'd14);
    endtask

    task automatic test_reset_mid_pass();
        int p, b; bit to; int bad = 0;
        load_mixed();
        do_reset(1'b0);
        run_list(1'b0, 0, 6, 500, p, b, to);
        tests_run++;
        if (b !== 6 || done !== 1'b0) begin
            tests_failed++; $display("FAIL abort_point: beats %0d done %b expected 6 and 0", b, done);
        end
        do_reset(1'b0);
        tests_run++;
        if (total !== 32'd0 || done !== 1'b0) begin
            tests_failed++; $display("FAIL mid_reset_clear: total %0d done %b expected 0 and 0", total, done);
        end
        run_list(1'b0, 0, -1, 500, p, b, to);
        check_run("replay", to, p, 8, b, 32, total, 32'd14);
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b1 || total !== 32'd14) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++; $display("FAIL done_sticky: done/total changed in %0d of 4 cycles", bad);
        end
    endtask

    task automatic test_wide_lanes();
        int p, b; bit to;
        prog[0] = mk(OP_TOGGLE, 0, 0, 39, 39); prog_len = 1;
        do_reset(1'b1);
        run_list(1'b1, 0, -1, 3000, p, b, to);
        check_run("wide_toggle", to, p, 200, b, 200, total2, 32'd3200);
        prog[0] = mk(OP_ON, 0, 0, 0, 0);
        do_reset(1'b1);
        run_list(1'b1, 0, -1, 3000, p, b, to);
        check_run("wide_single_on", to, p, 200, b, 200, total2, 32'd1);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_on();
        test_toggle_and_floor();
        test_mixed();
        test_gaps();
        test_reset_mid_pass();
        test_wide_lanes();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
